// File: rtl/vga_color_ctrl_pkg.sv
// Shared definitions for the VGA colour configuration controller:
// channel widths, reset colour, switch bit positions and the commit FSM state type.
package vga_pkg;

   localparam int R_W = 3;
   localparam int G_W = 3;
   localparam int B_W = 2;

   localparam logic [R_W-1:0] RST_R_DEF = 3'd7;
   localparam logic [G_W-1:0] RST_G_DEF = 3'd7;
   localparam logic [B_W-1:0] RST_B_DEF = 2'd3;

   // sw[7] selects load mode; the load value sits in the low bits
   localparam int SW_MODE = 7;
   localparam int SW_W    = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COMMIT  = 2'd2
   } state_e;

endpackage

// File: rtl/vga_color_ctrl_btn_debounce.sv
// Per-button conditioning: 2-flop synchronizer, stable-time debounce counter
// and a registered one-cycle pulse on every accepted 0->1 transition.
module btn_debounce #(
   parameter int DEB_CYCLES = 1000000,
   parameter int CNT_W      = 20
) (
   input  logic clk,
   input  logic clr,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic             rise_q;
   logic             rise_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count how long the synchronized input has disagreed with the accepted level
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
            rise_d  = ~level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Synchronizer, debounce counter, accepted level and rise pulse registers
   always_ff @(posedge clk) begin
      if (clr) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/vga_color_ctrl.sv
// VGA colour configuration controller: button steps edit a shadow colour,
// which is committed to the output levels only at the next vsync falling edge.
module vga_color_ctrl
   import vga_pkg::*;
#(
   parameter int             DEB_CYCLES = 1000000,
   parameter int             CNT_W      = 20,
   parameter logic [R_W-1:0] RST_R      = RST_R_DEF,
   parameter logic [G_W-1:0] RST_G      = RST_G_DEF,
   parameter logic [B_W-1:0] RST_B      = RST_B_DEF
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            btnr,
   input  logic            btng,
   input  logic            btnb,
   input  logic [SW_W-1:0] sw,
   input  logic            vsync_in,
   output logic [R_W-1:0]  red_lvl,
   output logic [G_W-1:0]  green_lvl,
   output logic [B_W-1:0]  blue_lvl,
   output logic            pending,
   output logic            cfg_valid
);

   logic            rise_r_s;
   logic            rise_g_s;
   logic            rise_b_s;
   logic            lvl_r_s;
   logic            lvl_g_s;
   logic            lvl_b_s;
   logic            lvl_unused_s;
   logic            edit_s;
   logic            mode_s;
   logic            frame_start_s;
   logic            commit_s;
   logic [3:0]      sw_unused_s;

   logic [SW_W-1:0] sw_s1_q;
   logic [SW_W-1:0] sw_s2_q;
   logic            vs_s1_q;
   logic            vs_s2_q;
   logic            vs_prev_q;

   logic [R_W-1:0]  shd_r_q, shd_r_d;
   logic [G_W-1:0]  shd_g_q, shd_g_d;
   logic [B_W-1:0]  shd_b_q, shd_b_d;

   state_e          state_q, state_d;
   logic [R_W-1:0]  red_lvl_q, red_lvl_d;
   logic [G_W-1:0]  green_lvl_q, green_lvl_d;
   logic [B_W-1:0]  blue_lvl_q, blue_lvl_d;
   logic            pending_q, pending_d;
   logic            cfg_valid_q, cfg_valid_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_r (
      .clk(clk), .clr(clr), .raw(btnr), .level(lvl_r_s), .rise(rise_r_s)
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_g (
      .clk(clk), .clr(clr), .raw(btng), .level(lvl_g_s), .rise(rise_g_s)
   );
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_b (
      .clk(clk), .clr(clr), .raw(btnb), .level(lvl_b_s), .rise(rise_b_s)
   );

   // Debounced levels and the middle switch bits are not needed by this block
   assign lvl_unused_s = lvl_r_s ^ lvl_g_s ^ lvl_b_s;
   assign sw_unused_s  = sw_s2_q[6:3];

   assign edit_s        = rise_r_s | rise_g_s | rise_b_s;
   assign mode_s        = sw_s2_q[SW_MODE];
   assign frame_start_s = vs_prev_q & ~vs_s2_q;
   assign commit_s      = (state_q == COMMIT);

   // Switch and vsync synchronizers plus the vsync edge-detect delay flop
   always_ff @(posedge clk) begin
      if (clr) begin
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
         vs_s1_q   <= 1'b0;
         vs_s2_q   <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         sw_s1_q   <= sw;
         sw_s2_q   <= sw_s1_q;
         vs_s1_q   <= vsync_in;
         vs_s2_q   <= vs_s1_q;
         vs_prev_q <= vs_s2_q;
      end
   end

   // Shadow colour edits: increment with wrap, or load from the switches
   always_comb begin
      shd_r_d = shd_r_q;
      shd_g_d = shd_g_q;
      shd_b_d = shd_b_q;
      if (rise_r_s) begin
         shd_r_d = mode_s ? sw_s2_q[2:0] : shd_r_q + 3'd1;
      end else begin
         shd_r_d = shd_r_q;
      end
      if (rise_g_s) begin
         shd_g_d = mode_s ? sw_s2_q[2:0] : shd_g_q + 3'd1;
      end else begin
         shd_g_d = shd_g_q;
      end
      if (rise_b_s) begin
         shd_b_d = mode_s ? sw_s2_q[1:0] : shd_b_q + 2'd1;
      end else begin
         shd_b_d = shd_b_q;
      end
   end

   // Shadow colour registers
   always_ff @(posedge clk) begin
      if (clr) begin
         shd_r_q <= RST_R;
         shd_g_q <= RST_G;
         shd_b_q <= RST_B;
      end else begin
         shd_r_q <= shd_r_d;
         shd_g_q <= shd_g_d;
         shd_b_q <= shd_b_d;
      end
   end

   // Commit FSM next state and registered output values
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (edit_s) state_d = PENDING;
            else        state_d = IDLE;
         end
         PENDING: begin
            if (frame_start_s) state_d = COMMIT;
            else               state_d = PENDING;
         end
         COMMIT: begin
            if (edit_s) state_d = PENDING;
            else        state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (commit_s) begin
         red_lvl_d   = shd_r_q;
         green_lvl_d = shd_g_q;
         blue_lvl_d  = shd_b_q;
      end else begin
         red_lvl_d   = red_lvl_q;
         green_lvl_d = green_lvl_q;
         blue_lvl_d  = blue_lvl_q;
      end
      cfg_valid_d = commit_s;
      pending_d   = (state_d == PENDING);
   end

   // Commit FSM state and its registered outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         red_lvl_q   <= RST_R;
         green_lvl_q <= RST_G;
         blue_lvl_q  <= RST_B;
         pending_q   <= 1'b0;
         cfg_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         red_lvl_q   <= red_lvl_d;
         green_lvl_q <= green_lvl_d;
         blue_lvl_q  <= blue_lvl_d;
         pending_q   <= pending_d;
         cfg_valid_q <= cfg_valid_d;
      end
   end

   assign red_lvl   = red_lvl_q;
   assign green_lvl = green_lvl_q;
   assign blue_lvl  = blue_lvl_q;
   assign pending   = pending_q;
   assign cfg_valid = cfg_valid_q;

endmodule

// File: tb/tb_vga_color_ctrl.sv
// Directed bench for vga_color_ctrl with a short debounce time (16 cycles).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same offset.
module tb_vga_color_ctrl;

   logic       clk = 1'b0;
   logic       clr;
   logic       btnr;
   logic       btng;
   logic       btnb;
   logic [7:0] sw;
   logic       vsync_in;
   logic [2:0] red_lvl;
   logic [2:0] green_lvl;
   logic [1:0] blue_lvl;
   logic       pending;
   logic       cfg_valid;

   int checks   = 0;
   int failures = 0;

   vga_color_ctrl #(.DEB_CYCLES(16), .CNT_W(5)) dut (
      .clk(clk), .clr(clr), .btnr(btnr), .btng(btng), .btnb(btnb), .sw(sw),
      .vsync_in(vsync_in), .red_lvl(red_lvl), .green_lvl(green_lvl),
      .blue_lvl(blue_lvl), .pending(pending), .cfg_valid(cfg_valid)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_lvls(input string tag, input logic [2:0] r, input logic [2:0] g,
                           input logic [1:0] b);
      chk({tag, "_red"},   {5'd0, red_lvl},   {5'd0, r});
      chk({tag, "_green"}, {5'd0, green_lvl}, {5'd0, g});
      chk({tag, "_blue"},  {6'd0, blue_lvl},  {6'd0, b});
   endtask

   initial begin
      clr = 1'b1; btnr = 1'b0; btng = 1'b0; btnb = 1'b0; sw = 8'h00; vsync_in = 1'b1;
      step(2);
      clr = 1'b0;
      chk_lvls("reset", 3'd7, 3'd7, 2'd3);
      chk("reset_pend", {7'd0, pending}, 8'd0);
      chk("reset_cfg", {7'd0, cfg_valid}, 8'd0);
      step(4);

      // Bouncing red button: 10 high / 5 low never lasts long enough
      for (int i = 0; i < 4; i++) begin
         btnr = 1'b1; step(10);
         btnr = 1'b0; step(5);
      end
      step(25);
      chk("bounce_pend", {7'd0, pending}, 8'd0);
      chk_lvls("bounce", 3'd7, 3'd7, 2'd3);
      vsync_in = 1'b0; step(4);
      chk("idle_vs_cfg", {7'd0, cfg_valid}, 8'd0);
      vsync_in = 1'b1; step(4);

      // Blue increment 3 -> 0, visible as pending at edge 19 after the press
      btnb = 1'b1; step(18);
      chk("blue_pend_e18", {7'd0, pending}, 8'd0);
      step(1);
      chk("blue_pend_e19", {7'd0, pending}, 8'd1);
      step(21); btnb = 1'b0; step(25);
      chk("blue_pend_hold", {7'd0, pending}, 8'd1);
      chk("blue_lvl_pre", {6'd0, blue_lvl}, 8'd3);
      vsync_in = 1'b0; step(3);
      chk("blue_cfg_e3", {7'd0, cfg_valid}, 8'd0);
      chk("blue_lvl_e3", {6'd0, blue_lvl}, 8'd3);
      step(1);
      chk("blue_cfg_e4", {7'd0, cfg_valid}, 8'd1);
      chk_lvls("blue_commit", 3'd7, 3'd7, 2'd0);
      chk("blue_pend_post", {7'd0, pending}, 8'd0);
      step(1);
      chk("blue_cfg_e5", {7'd0, cfg_valid}, 8'd0);
      vsync_in = 1'b1; step(5);

      // Load mode: red and green pressed together load sw[2:0] = 5
      sw = 8'h85; step(4);
      btnr = 1'b1; btng = 1'b1; step(19);
      chk("load_pend", {7'd0, pending}, 8'd1);
      step(21); btnr = 1'b0; btng = 1'b0; step(25);
      vsync_in = 1'b0; step(4);
      chk("load_cfg", {7'd0, cfg_valid}, 8'd1);
      chk_lvls("load_commit", 3'd5, 3'd5, 2'd0);
      step(1); vsync_in = 1'b1; step(5);

      // Blue edit (0 -> 1) pending, then a green step landing in the COMMIT cycle
      sw = 8'h00; step(4);
      btnb = 1'b1; step(40); btnb = 1'b0; step(25);
      chk("ec_pend_pre", {7'd0, pending}, 8'd1);
      btng = 1'b1; step(15);
      vsync_in = 1'b0; step(3);
      chk("ec_cfg_e3", {7'd0, cfg_valid}, 8'd0);
      step(1);
      chk("ec_cfg_e4", {7'd0, cfg_valid}, 8'd1);
      chk_lvls("ec_commit", 3'd5, 3'd5, 2'd1);
      chk("ec_pend_e4", {7'd0, pending}, 8'd1);
      step(1);
      chk("ec_cfg_e5", {7'd0, cfg_valid}, 8'd0);
      chk("ec_pend_e5", {7'd0, pending}, 8'd1);
      vsync_in = 1'b1; step(20); btng = 1'b0; step(25);
      vsync_in = 1'b0; step(4);
      chk("ec2_cfg", {7'd0, cfg_valid}, 8'd1);
      chk_lvls("ec2_commit", 3'd5, 3'd6, 2'd1);
      chk("ec2_pend", {7'd0, pending}, 8'd0);
      step(1); vsync_in = 1'b1; step(5);

      // Edit then reset before the frame boundary: nothing gets committed
      btnr = 1'b1; step(19);
      chk("rst_pend_pre", {7'd0, pending}, 8'd1);
      step(21); btnr = 1'b0; step(25);
      clr = 1'b1; step(2); clr = 1'b0;
      chk_lvls("rst_mid", 3'd7, 3'd7, 2'd3);
      chk("rst_mid_pend", {7'd0, pending}, 8'd0);
      chk("rst_mid_cfg", {7'd0, cfg_valid}, 8'd0);
      step(4);
      vsync_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("rst_vs_cfg", {7'd0, cfg_valid}, 8'd0);
      end
      chk_lvls("rst_vs", 3'd7, 3'd7, 2'd3);
      vsync_in = 1'b1; step(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
